uart_rx_control: RTL and testbench
==================================

Name: uart_rx_control

Overview:
- Receive-side counterpart of the UART transmit controller: deserialises 8N1 UART frames from the board RXD pin.
- Stores the first DATA_LEN received bytes in an internal buffer and flags completion.
- The buffer is readable through a combinational read port.
- Sits between the FPGA RXD pin and downstream logic that loads received data (e.g. a test vector or weight buffer).

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud).
- DATA_BITS, 8, data bits per frame, sent LSB first.
- DATA_LEN, 4, number of bytes captured before done.
- IDX_W, 3, width of rd_addr and count; must satisfy 2^IDX_W > DATA_LEN.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- start  input  1  arm: gates start-bit detection.
- RXD  input  1  asynchronous serial input, idle high.
- rd_addr  input  IDX_W  buffer read index.
- rd_data  output  DATA_BITS  buffer[rd_addr], combinational; returns 0 when rd_addr >= DATA_LEN.
- count  output  IDX_W  bytes stored so far.
- byte_valid  output  1  one-cycle pulse per stored byte.
- frame_err  output  1  sticky; set on a bad stop bit.
- done  output  1  high once count == DATA_LEN.

Behaviour:
- One clock (CLK100MHZ). Reset is synchronous and active-high; all registers are sampled on the CLK100MHZ rising edge.
- Reset values:
  - count = 0, byte_valid = 0, frame_err = 0, done = 0.
  - All buffer entries = 0; shift register and bit/baud counters = 0.
  - Synchroniser flops = 1; state = S_IDLE.
- RXD passes through a 2-flop synchroniser (rxs). All timing below is relative to rxs.
- State machine:
  - S_IDLE: if start = 1, done = 0, rxs = 0 and line_ready = 1 -> S_START, baud counter cleared.
  - S_START: at CLKS_PER_BIT/2 - 1 cycles (433), sample rxs.
    - rxs = 0 -> S_DATA, counters cleared.
    - rxs = 1 -> glitch: S_IDLE, nothing recorded.
  - S_DATA: every CLKS_PER_BIT cycles (baud counter == CLKS_PER_BIT - 1), shift rxs into the shift register at the MSB and shift right.
    - After DATA_BITS samples -> S_STOP.
  - S_STOP: after CLKS_PER_BIT cycles, sample rxs.
    - rxs = 1: buffer[count] <= shift register; count <= count + 1; byte_valid = 1 on the next cycle, for exactly one cycle.
    - rxs = 0: frame_err <= 1; byte discarded; count unchanged; line_ready <= 0.
    - Either way -> S_IDLE, or S_END if count becomes DATA_LEN.
  - S_END: done = 1; RXD ignored; held until reset.
- line_ready:
  - Cleared after a framing error.
  - Set when rxs = 1 for one sample.
  - Prevents a stuck-low line from re-triggering.
- start:
  - Only gates start-bit detection.
  - A frame already in progress completes even if start falls.
  - start is ignored in S_END.
- Latency: byte_valid rises CLKS_PER_BIT*(DATA_BITS+1) + CLKS_PER_BIT/2 + 1 cycles after the rxs falling edge of the start bit (nominal 8247 cycles for defaults).
- Simultaneous events:
  - reset has priority over everything.
  - byte_valid and the done transition occur in the same cycle for the last byte (done registered with the count update).
- Reset mid-frame: the next edge returns all state to reset values; the partial byte is lost.
- Baud counter width: clog2(CLKS_PER_BIT). It is cleared on each sample and never wraps past CLKS_PER_BIT - 1.

Test Plan:
1. Normal load:
   - Stimulus: reset, start = 1, send 0xA1, 0xB2, 0xC3, 0xD4 at 868 clk/bit with 2 idle bits between frames.
   - Required: four byte_valid pulses; count steps 1..4; done = 1 on the 4th pulse; rd_data at addr 0..3 = A1, B2, C3, D4; frame_err = 0; rd_addr = 5 gives 0.
2. Glitch rejection:
   - Stimulus: start = 1, drive RXD low for 200 cycles, then high.
   - Required: no byte_valid; count = 0; state returns to S_IDLE; a following 0x5A frame is stored at index 0.
3. Framing error:
   - Stimulus: send 0x55 with stop bit = 0, hold RXD low 2000 cycles, release high, then send 0x3C.
   - Required: frame_err = 1 and stays 1; no reception while the line is low; 0x3C stored at index 0; count = 1.
4. Gating:
   - Stimulus: start = 0, send 0xA1; then start = 1, send 0x77.
   - Required: 0xA1 ignored; 0x77 stored at index 0.
5. Post-done:
   - Stimulus: after scenario 1, send 0xEE.
   - Required: no byte_valid; count stays 4; buffer unchanged.
6. Reset mid-frame:
   - Stimulus: assert reset for 1 cycle after 3 data bits of 0xFF, then send 0x81.
   - Required: all outputs 0 on the cycle after reset; 0x81 stored at index 0; count = 1.

Source files
------------

// File: rtl/uart_rx_control.sv
// 8N1 UART receiver: captures the first DATA_LEN bytes from RXD into a small
// buffer with a combinational read port, then holds done until reset.
module uart_rx_control #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int DATA_LEN     = 4,
    parameter int IDX_W        = 3
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 RXD,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [IDX_W-1:0]     count,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam int DEPTH  = 2 ** IDX_W;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  LEN_C     = IDX_W'(DATA_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_END
    } state_t;

    state_t state, state_nx;

    logic                 rx_meta, rxs;
    logic                 line_ready;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] buffer [0:DEPTH-1];
    logic [IDX_W-1:0]     count_inc;

    logic baud_clr, bit_clr, shift_en, store, ferr_set;

    assign count_inc = count + IDX_W'(1);

    always_comb begin
        state_nx = state;
        baud_clr = 1'b0;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        store    = 1'b0;
        ferr_set = 1'b0;
        case (state)
            S_IDLE: begin
                baud_clr = 1'b1;
                bit_clr  = 1'b1;
                // line_ready keeps a stuck-low line from looking like a new start bit
                if (start && !done && !rxs && line_ready)
                    state_nx = S_START;
            end
            S_START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_clr = 1'b1;
                    state_nx = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST)
                        state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_clr = 1'b1;
                    store    = rxs;
                    ferr_set = !rxs;
                    state_nx = (rxs && count_inc == LEN_C) ? S_END : S_IDLE;
                end
            end
            S_END: begin
                baud_clr = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
                baud_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state      <= S_IDLE;
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            line_ready <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            count      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                buffer[i] <= '0;
        end else begin
            state      <= state_nx;
            rx_meta    <= RXD;
            rxs        <= rx_meta;
            byte_valid <= store;
            baud_cnt   <= baud_clr ? '0 : baud_cnt + BAUD_W'(1);
            if (bit_clr)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + BIT_W'(1);
            if (shift_en)
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
            // done is registered together with the final count update
            if (store) begin
                buffer[count] <= shreg;
                count         <= count_inc;
                done          <= (count_inc == LEN_C);
            end
            if (ferr_set) begin
                frame_err  <= 1'b1;
                line_ready <= 1'b0;
            end else if (rxs) begin
                line_ready <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < LEN_C)
            rd_data = buffer[rd_addr];
    end

endmodule

// File: tb/tb_uart_rx_control.sv
// Directed bench for uart_rx_control; bit time is scaled to 100 clocks to keep
// the run short, all expected values are hand-computed for that bit time.
module tb_uart_rx_control;

    localparam int CPB = 100;
    // start-bit drive to first byte_valid: 2 sync flops + CPB*9 + CPB/2 + 1
    localparam int LAT = 953;

    logic       CLK100MHZ = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       RXD       = 1'b1;
    logic [2:0] rd_addr   = 3'd0;
    logic [7:0] rd_data;
    logic [2:0] count;
    logic       byte_valid, frame_err, done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bv_total = 0;
    int t0, b0;
    int         bv_cyc  [0:31];
    logic [2:0] bv_count[0:31];
    logic       bv_done [0:31];

    uart_rx_control #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .DATA_LEN(4),
        .IDX_W(3)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .start     (start),
        .RXD       (RXD),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .count     (count),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .done      (done)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cyc++;

    always @(negedge CLK100MHZ) begin
        if (byte_valid === 1'b1) begin
            if (bv_total < 32) begin
                bv_cyc[bv_total]   = cyc;
                bv_count[bv_total] = count;
                bv_done[bv_total]  = done;
            end
            bv_total++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RXD = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            wait_cyc(CPB);
        end
        RXD = stop_bit;
        wait_cyc(CPB);
        if (stop_bit)
            wait_cyc(2 * CPB);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        wait_cyc(3);
        reset = 1'b0;

        // reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_bv", 32'(byte_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rd(3'd0, d); check("rst_buf0", 32'(d), 32'd0);

        // normal load of four bytes
        start = 1'b1;
        t0 = cyc;
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hD4, 1'b1);
        check("load_pulses", 32'(bv_total), 32'd4);
        check("load_latency", 32'(bv_cyc[0] - t0), 32'(LAT));
        check("load_cnt_p1", 32'(bv_count[0]), 32'd1);
        check("load_cnt_p2", 32'(bv_count[1]), 32'd2);
        check("load_cnt_p3", 32'(bv_count[2]), 32'd3);
        check("load_cnt_p4", 32'(bv_count[3]), 32'd4);
        check("load_done_p3", 32'(bv_done[2]), 32'd0);
        check("load_done_p4", 32'(bv_done[3]), 32'd1);
        rd(3'd0, d); check("load_buf0", 32'(d), 32'hA1);
        rd(3'd1, d); check("load_buf1", 32'(d), 32'hB2);
        rd(3'd2, d); check("load_buf2", 32'(d), 32'hC3);
        rd(3'd3, d); check("load_buf3", 32'(d), 32'hD4);
        rd(3'd4, d); check("load_buf4_oob", 32'(d), 32'd0);
        rd(3'd5, d); check("load_buf5_oob", 32'(d), 32'd0);
        check("load_ferr", 32'(frame_err), 32'd0);

        // post-done: further frames are ignored
        send_byte(8'hEE, 1'b1);
        check("post_pulses", 32'(bv_total), 32'd4);
        check("post_count", 32'(count), 32'd4);
        check("post_done", 32'(done), 32'd1);
        rd(3'd0, d); check("post_buf0", 32'(d), 32'hA1);
        rd(3'd3, d); check("post_buf3", 32'(d), 32'hD4);

        // glitch shorter than half a bit is rejected
        do_reset();
        b0 = bv_total;
        RXD = 1'b0;
        wait_cyc(30);
        RXD = 1'b1;
        wait_cyc(2 * CPB);
        check("glitch_pulses", 32'(bv_total - b0), 32'd0);
        check("glitch_count", 32'(count), 32'd0);
        send_byte(8'h5A, 1'b1);
        rd(3'd0, d); check("glitch_buf0", 32'(d), 32'h5A);
        check("glitch_count2", 32'(count), 32'd1);

        // framing error, stuck-low line, then recovery
        do_reset();
        b0 = bv_total;
        send_byte(8'h55, 1'b0);
        wait_cyc(2000);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_count", 32'(count), 32'd0);
        check("ferr_pulses", 32'(bv_total - b0), 32'd0);
        RXD = 1'b1;
        wait_cyc(2 * CPB);
        send_byte(8'h3C, 1'b1);
        check("ferr_sticky", 32'(frame_err), 32'd1);
        check("ferr_count2", 32'(count), 32'd1);
        rd(3'd0, d); check("ferr_buf0", 32'(d), 32'h3C);

        // start gating
        do_reset();
        check("gate_ferr_clr", 32'(frame_err), 32'd0);
        b0 = bv_total;
        start = 1'b0;
        send_byte(8'hA1, 1'b1);
        check("gate_pulses", 32'(bv_total - b0), 32'd0);
        check("gate_count", 32'(count), 32'd0);
        start = 1'b1;
        send_byte(8'h77, 1'b1);
        check("gate_count2", 32'(count), 32'd1);
        rd(3'd0, d); check("gate_buf0", 32'(d), 32'h77);

        // reset in the middle of a 0xFF frame
        RXD = 1'b0;
        wait_cyc(CPB);
        RXD = 1'b1;
        wait_cyc(3 * CPB);
        do_reset();
        check("mid_count", 32'(count), 32'd0);
        check("mid_bv", 32'(byte_valid), 32'd0);
        check("mid_ferr", 32'(frame_err), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        rd(3'd0, d); check("mid_buf0", 32'(d), 32'd0);
        wait_cyc(6 * CPB);
        send_byte(8'h81, 1'b1);
        rd(3'd0, d); check("mid_buf0_new", 32'(d), 32'h81);
        check("mid_count2", 32'(count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
